// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: bus widths, the NOP
// word, the queue entry layout and a pointer-width helper.
package if_prefetch_pkg;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;

  typedef logic [INST_BUS_W-1:0]      inst_t;
  typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;

  // addi x0, x0, 0 -- presented to decode whenever no instruction is valid
  localparam inst_t      INST_NOP  = 32'h0000_0013;
  localparam inst_addr_t ZERO_WORD = '0;

  // One prefetch queue entry: the instruction and the address it came from.
  typedef struct packed {
    inst_addr_t addr;
    inst_t      inst;
  } fetch_entry_t;

  // Width of a read/write pointer into a queue of the given depth.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction bus between the prefetch unit (master) and instruction memory
// (slave). Requests are address/grant; responses come back in order.
interface if_prefetch_if;
  import if_prefetch_pkg::*;

  logic       ibus_req_o;
  inst_addr_t ibus_addr_o;
  logic       ibus_gnt_i;
  logic       ibus_rvalid_i;
  inst_t      ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i
  );

endinterface

// File: rtl/if_prefetch_fetch_fifo.sv
// Prefetch queue: DEPTH entries of {addr, inst}. Head is visible
// combinationally; flush empties the queue and wins over a same-cycle push.
module fetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  fetch_entry_t      din,
  input  logic              pop,
  input  logic              flush,
  output logic [ptr_width(DEPTH):0] count,
  output fetch_entry_t      head
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  // A pop against an empty queue is ignored rather than corrupting pointers.
  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy update; flush clears everything.
  // NOTE: sequential state uses <= so every flop sees pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage write; contents are qualified by count, never read when stale.
  // NOTE: the data array has no reset -- pointers/count alone define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Overflow guard: the upstream credit check must keep pushes off a full queue.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push && !do_pop)
      assert (count < CW'(DEPTH)) else $error("fetch_fifo overflow: push with queue full");
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit feeding the if_id register. Issues word fetches,
// buffers responses in a DEPTH-entry queue, and on a jump flushes the queue,
// redirects, and drops responses still in flight for the old path.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000,
  parameter int         DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  if_prefetch_if.master ibus,
  input  logic         jump_flag_i,
  input  inst_addr_t   jump_addr_i,
  input  logic         hold_i,
  output logic         inst_valid_o,
  output inst_t        inst_o,
  output inst_addr_t   inst_addr_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;          // holds 0..DEPTH

  inst_addr_t   pc;                    // next fetch address
  inst_addr_t   resp_pc;               // address of the next accepted response
  logic [CW-1:0] outstanding;          // granted requests not yet answered
  logic [CW-1:0] discard_cnt;          // in-flight responses belonging to a dead path
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  inst_addr_t    jump_target;
  logic          pop;
  logic          push;
  logic          issue;
  logic          grant;

  assign jump_target = jump_addr_i & ~inst_addr_t'(3);

  // Decode consumes the head unless stalled; a jump kills the head instead.
  assign pop = inst_valid_o & ~hold_i & ~jump_flag_i;

  // Queue slots plus in-flight requests may never exceed DEPTH, counting the
  // slot freed by this cycle's pop so streaming runs without bubbles.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - (CW+1)'(pop);
  assign issue       = ~rst & ~jump_flag_i & (credit_used < (CW+1)'(DEPTH));
  assign grant       = issue & ibus.ibus_gnt_i;

  assign ibus.ibus_req_o  = issue;
  assign ibus.ibus_addr_o = pc;

  // Responses for a dead path and anything arriving alongside a jump are dropped.
  assign push       = ibus.ibus_rvalid_i & ~jump_flag_i & (discard_cnt == '0);
  assign push_entry = '{addr: resp_pc, inst: ibus.ibus_rdata_i};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (jump_flag_i),
    .count (fifo_count),
    .head  (head)
  );

  // Fetch/response address tracking, in-flight accounting and jump redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(ibus.ibus_rvalid_i);
      if (jump_flag_i) begin
        pc          <= jump_target;
        resp_pc     <= jump_target;
        discard_cnt <= outstanding - CW'(ibus.ibus_rvalid_i);
      end else begin
        if (grant) pc      <= pc + 32'd4;
        if (push)  resp_pc <= resp_pc + 32'd4;
        if (ibus.ibus_rvalid_i && (discard_cnt != '0))
          discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

  assign inst_valid_o = (fifo_count != '0);
  assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
  assign inst_addr_o  = inst_valid_o ? head.addr : ZERO_WORD;

endmodule
